// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: free-running h/v counters advanced on pix_en,
// with registered sync, display-active and line/frame start pulses.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             active_next;
    logic             hsync_next;
    logic             vsync_next;

    // Decode works on the post-increment counts so the registered syncs and
    // active flag line up with the registered counters with no extra latency.
    always_comb begin
        h_wrap = (hcount == CNT_W'(H_TOTAL - 1));
        v_wrap = (vcount == CNT_W'(V_TOTAL - 1));
        h_next = h_wrap ? '0 : hcount + 1'b1;
        v_next = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcount + 1'b1;
        end
        active_next = (h_next < CNT_W'(H_VISIBLE)) && (v_next < CNT_W'(V_VISIBLE));
        hsync_next  = ((h_next >= CNT_W'(H_SYNC_START)) && (h_next < CNT_W'(H_SYNC_END)))
                      ? HSYNC_POL : ~HSYNC_POL;
        vsync_next  = ((v_next >= CNT_W'(V_SYNC_START)) && (v_next < CNT_W'(V_SYNC_END)))
                      ? VSYNC_POL : ~VSYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            active      <= 1'b1;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && h_wrap;
            frame_start <= pix_en && h_wrap && v_wrap;
            if (pix_en) begin
                hcount <= h_next;
                vcount <= v_next;
                active <= active_next;
                hsync  <= hsync_next;
                vsync  <= vsync_next;
            end
        end
    end

endmodule
